// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the NPC core front end.
//   - Default widths / reset vector / instruction size for the PC generator.
//   - pc_state_t       : PC generator control state (BOOT, RUN).
//   - redirect_cause_t : why the fetch stream was redirected. The CSR/trap
//                        unit uses the same encoding.
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h8000_0000;
  localparam int          INST_BYTES_DEF   = 4;
  localparam int          BOOT_CYCLES_DEF  = 2;
  localparam int          EPOCH_W_DEF      = 2;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_TRAP   = 2'd2
  } redirect_cause_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// ---------------------------------------------------------------------------
// pc_redirect_arb
// Combinational redirect arbiter: trap beats branch. The winning target is
// aligned down to an instruction boundary and a misalignment flag is raised
// when any of the discarded low bits were set.
//   i_trap_valid / i_trap_target : trap / mret redirect request
//   i_br_valid   / i_br_target   : branch / jump redirect request
//   o_cause                      : REDIR_NONE, REDIR_BRANCH or REDIR_TRAP
//   o_target                     : aligned winning target ('0 when none)
//   o_misalign                   : winning target had non-zero low bits
// ---------------------------------------------------------------------------
module pc_redirect_arb
  import core_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int INST_BYTES = INST_BYTES_DEF
) (
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_target,
  input  logic            i_br_valid,
  input  logic [XLEN-1:0] i_br_target,
  output redirect_cause_t o_cause,
  output logic [XLEN-1:0] o_target,
  output logic            o_misalign
);

  // INST_BYTES is a power of two, so INST_BYTES-1 covers exactly the
  // offset bits inside one instruction.
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INST_BYTES - 1);

  logic [XLEN-1:0] w_raw_target;

  always_comb begin
    o_cause      = REDIR_NONE;
    w_raw_target = '0;
    if (i_trap_valid) begin
      o_cause      = REDIR_TRAP;
      w_raw_target = i_trap_target;
    end else if (i_br_valid) begin
      o_cause      = REDIR_BRANCH;
      w_raw_target = i_br_target;
    end
  end

  assign o_target   = w_raw_target & ~LOW_MASK;
  assign o_misalign = |(w_raw_target & LOW_MASK);

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Fetch program-counter generator. Owns the fetch PC and offers it to
// instruction fetch over a valid/ready handshake, advancing by INST_BYTES on
// each accepted fetch. Trap and branch redirects (trap wins) replace the PC
// and bump the epoch so stale in-flight fetches can be discarded.
//
// Handshake: pc_valid depends only on state and stall, never on pc_ready.
// A transfer (fire) happens on a rising edge where pc_valid & pc_ready. While
// pc_valid is high, pc holds until fire, except that a redirect may replace
// it at any edge.
//
// Ports:
//   clk, rst                   : clock; asynchronous active-low reset
//   stall                      : back-end hold, forces pc_valid low
//   br_valid,   br_target      : branch / jump redirect
//   trap_valid, trap_target    : trap / mret redirect (priority over branch)
//   pc_valid, pc_ready, pc     : fetch handshake and current fetch PC
//   epoch                      : increments on every applied redirect
//   align_err                  : one-cycle pulse, applied target was misaligned
//   dbg_state                  : current control state (BOOT / RUN)
// ---------------------------------------------------------------------------
module pc_gen
  import core_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int              INST_BYTES   = INST_BYTES_DEF,
  parameter int              BOOT_CYCLES  = BOOT_CYCLES_DEF,
  parameter int              EPOCH_W      = EPOCH_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_valid,
  input  logic [XLEN-1:0]    br_target,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_target,
  output logic               pc_valid,
  input  logic               pc_ready,
  output logic [XLEN-1:0]    pc,
  output logic [EPOCH_W-1:0] epoch,
  output logic               align_err,
  output pc_state_t          dbg_state
);

  localparam int CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int BOOT_LAST = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;

  pc_state_t          r_state;
  pc_state_t          w_state_nxt;
  logic [CNT_W-1:0]   r_boot_cnt;
  logic [XLEN-1:0]    r_pc;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_align_err;
  logic               r_pend_valid;
  logic [XLEN-1:0]    r_pend_target;
  logic               r_pend_misalign;

  redirect_cause_t    w_live_cause;
  logic [XLEN-1:0]    w_live_target;
  logic               w_live_misalign;
  logic               w_live_valid;
  logic               w_boot_done;
  logic               w_boot_exit;
  logic               w_eff_valid;
  logic [XLEN-1:0]    w_eff_target;
  logic               w_eff_misalign;
  logic               w_apply;
  logic               w_fire;

  // One arbiter serves both the live RUN path and capture during BOOT.
  pc_redirect_arb #(
    .XLEN       (XLEN),
    .INST_BYTES (INST_BYTES)
  ) u_arb (
    .i_trap_valid  (trap_valid),
    .i_trap_target (trap_target),
    .i_br_valid    (br_valid),
    .i_br_target   (br_target),
    .o_cause       (w_live_cause),
    .o_target      (w_live_target),
    .o_misalign    (w_live_misalign)
  );

  assign w_live_valid = (w_live_cause != REDIR_NONE);

  // With BOOT_CYCLES == 0 the first edge after reset release leaves BOOT.
  assign w_boot_done = (BOOT_CYCLES == 0) || (r_boot_cnt == CNT_W'(BOOT_LAST));
  assign w_boot_exit = (r_state == BOOT) && w_boot_done;

  // A request arriving on the BOOT->RUN edge is the newest one, so it
  // overrides anything already parked in the pending register.
  assign w_eff_valid    = w_live_valid | r_pend_valid;
  assign w_eff_target   = w_live_valid ? w_live_target   : r_pend_target;
  assign w_eff_misalign = w_live_valid ? w_live_misalign : r_pend_misalign;

  assign w_apply = ((r_state == RUN) && w_live_valid) || (w_boot_exit && w_eff_valid);

  assign pc_valid = (r_state == RUN) && !stall;
  assign w_fire   = pc_valid && pc_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    if (w_boot_done) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_boot_cnt      <= '0;
      r_pc            <= RESET_VECTOR;
      r_epoch         <= '0;
      r_align_err     <= 1'b0;
      r_pend_valid    <= 1'b0;
      r_pend_target   <= '0;
      r_pend_misalign <= 1'b0;
    end else begin
      r_align_err <= w_apply && w_eff_misalign;

      // A redirect discards any sequential advance in the same cycle.
      if (w_apply) begin
        r_pc    <= w_eff_target;
        r_epoch <= r_epoch + EPOCH_W'(1);
      end else if (w_fire) begin
        r_pc <= r_pc + XLEN'(INST_BYTES);
      end

      if (r_state == BOOT) begin
        r_boot_cnt <= r_boot_cnt + CNT_W'(1);
        if (w_boot_exit) begin
          r_pend_valid <= 1'b0;
        end else if (w_live_valid) begin
          r_pend_valid    <= 1'b1;
          r_pend_target   <= w_live_target;
          r_pend_misalign <= w_live_misalign;
        end
      end
    end
  end

  assign pc        = r_pc;
  assign epoch     = r_epoch;
  assign align_err = r_align_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  import core_pkg::*;

  localparam int          XLEN        = 32;
  localparam int          EPOCH_W     = 2;
  localparam int          INST_BYTES  = 4;
  localparam int          BOOT_CYCLES = 2;
  localparam logic [31:0] RV          = 32'h8000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               stall = 1'b0;
  logic               br_valid = 1'b0;
  logic [XLEN-1:0]    br_target = '0;
  logic               trap_valid = 1'b0;
  logic [XLEN-1:0]    trap_target = '0;
  logic               pc_ready = 1'b0;
  logic               pc_valid;
  logic [XLEN-1:0]    pc;
  logic [EPOCH_W-1:0] epoch;
  logic               align_err;
  pc_state_t          dbg_state;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .INST_BYTES   (INST_BYTES),
    .BOOT_CYCLES  (BOOT_CYCLES),
    .EPOCH_W      (EPOCH_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .pc          (pc),
    .epoch       (epoch),
    .align_err   (align_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [EPOCH_W-1:0] epoch;
    logic               align;
  } stat_t;

  stat_t                    stat_q[$];   // per-cycle expected outputs
  logic [EPOCH_W+XLEN-1:0]  exp_q[$];    // expected {epoch, pc} of each accepted fetch
  int                       n_checks = 0;
  int                       n_errors = 0;
  bit                       chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behavioural view: a boot countdown, a parked redirect, and the PC/epoch.
  bit          m_run;
  int          m_boot_left;
  logic [31:0] m_pc;
  int          m_epoch;
  bit          m_align;
  bit          m_pend;
  logic [31:0] m_pend_tgt;

  function automatic logic [31:0] align_down(input logic [31:0] t);
    return (t / INST_BYTES) * INST_BYTES;
  endfunction

  task automatic model_reset();
    m_run       = 1'b0;
    m_boot_left = BOOT_CYCLES;
    m_pc        = RV;
    m_epoch     = 0;
    m_align     = 1'b0;
    m_pend      = 1'b0;
    m_pend_tgt  = '0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    m_pc    = align_down(t);
    m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
    m_align = (t % INST_BYTES) != 0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input bit s, input bit bv, input logic [31:0] bt,
                            input bit tv, input logic [31:0] tt, input bit rdy);
    bit          redir;
    logic [31:0] tgt;
    redir   = tv || bv;
    tgt     = tv ? tt : bt;
    m_align = 1'b0;
    if (!m_run) begin
      if (redir) begin
        m_pend     = 1'b1;
        m_pend_tgt = tgt;
      end
      if (m_boot_left <= 1) begin
        m_run = 1'b1;
        if (m_pend) redirect_to(m_pend_tgt);
        m_pend = 1'b0;
      end else begin
        m_boot_left--;
      end
    end else begin
      if (redir) redirect_to(tgt);
      else if (!s && rdy) m_pc = m_pc + INST_BYTES;
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+2: drives one cycle of inputs, records what the DUT
  // should show during this cycle, then steps to the next posedge+2.
  task automatic cycle(input bit s, input bit bv, input logic [31:0] bt,
                       input bit tv, input logic [31:0] tt, input bit rdy);
    stat_t e;
    bit    v;
    stall       = s;
    br_valid    = bv;
    br_target   = bt;
    trap_valid  = tv;
    trap_target = tt;
    pc_ready    = rdy;
    v       = m_run && !s;
    e.valid = v;
    e.pc    = m_pc;
    e.epoch = EPOCH_W'(m_epoch);
    e.align = m_align;
    stat_q.push_back(e);
    if (v && rdy) exp_q.push_back({EPOCH_W'(m_epoch), m_pc});
    model_step(s, bv, bt, tv, tt, rdy);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, rdy);
  endtask

  // Asserts reset between edges, checks the immediate reset values, then
  // releases at posedge+2.
  task automatic do_reset();
    chk_en      = 1'b0;
    stall       = 1'b0;
    br_valid    = 1'b0;
    trap_valid  = 1'b0;
    pc_ready    = 1'b0;
    #6;
    rst = 1'b0;
    #1;
    check("rst_pc", pc, RV);
    check("rst_pc_valid", pc_valid, 1'b0);
    check("rst_epoch", epoch, '0);
    check("rst_align_err", align_err, 1'b0);
    stat_q.delete();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
  endtask

  // ---------------- monitor ----------------
  stat_t                   mon_s;
  logic [EPOCH_W+XLEN-1:0] mon_e;

  always @(negedge clk) begin
    if (chk_en) begin
      if (stat_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL stat_q_empty: got no expectation, required one (t=%0t)", $time);
      end else begin
        mon_s = stat_q.pop_front();
        check("pc_valid", pc_valid, mon_s.valid);
        check("pc", pc, mon_s.pc);
        check("epoch", epoch, mon_s.epoch);
        check("align_err", align_err, mon_s.align);
      end
      if (pc_valid && pc_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL fire_unexpected: got fire pc=%0h, required no fire (t=%0t)", pc, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("fire_pc", pc, mon_e[XLEN-1:0]);
          check("fire_epoch", epoch, mon_e[EPOCH_W+XLEN-1:XLEN]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t_br;
    logic [31:0] t_tr;

    // Reset / boot, sequential fetch
    do_reset();
    idle(4, 1'b1);                 // 2 boot cycles, then 0x8000_0000, 0x8000_0004 accepted
    check("seq_pc_08", pc, 32'h8000_0008);

    // Backpressure at 0x8000_0008
    idle(3, 1'b0);
    check("bp_pc_held", pc, 32'h8000_0008);
    idle(1, 1'b1);
    check("bp_next_pc", pc, 32'h8000_000C);

    // Trap beats branch in the same cycle, fetch also firing
    cycle(1'b0, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0100, 1'b1);
    check("prio_pc", pc, 32'h8000_0100);
    check("prio_epoch", epoch, 2'd1);
    idle(2, 1'b1);

    // Redirect captured during BOOT, misaligned target
    do_reset();
    cycle(1'b0, 1'b1, 32'h8000_0042, 1'b0, '0, 1'b1);
    idle(1, 1'b1);
    check("boot_cap_pc", pc, 32'h8000_0040);
    check("boot_cap_epoch", epoch, 2'd1);
    check("boot_cap_align", align_err, 1'b1);
    idle(2, 1'b1);

    // Stall with wrap-around
    cycle(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    check("stall_pc_held", pc, 32'hFFFF_FFFC);
    idle(1, 1'b1);
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_epoch", epoch, 2'd2);

    // Branch during stall applies immediately
    cycle(1'b1, 1'b1, 32'h8000_0300, 1'b0, '0, 1'b1);
    check("stall_redir_pc", pc, 32'h8000_0300);
    idle(1, 1'b1);

    // Async reset mid-run with pc=0x8000_0020, epoch=3
    do_reset();
    idle(2, 1'b0);
    cycle(1'b0, 1'b1, 32'h8000_0010, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 32'h8000_0018, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 32'h8000_0020, 1'b0, '0, 1'b1);
    check("pre_rst_pc", pc, 32'h8000_0020);
    check("pre_rst_epoch", epoch, 2'd3);
    do_reset();

    // Randomized traffic, occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        t_br = $urandom();
        t_tr = $urandom();
        if ($urandom_range(0, 7) == 0) t_br = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
        if ($urandom_range(0, 7) == 0) t_tr = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
        cycle($urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0, t_br,
              $urandom_range(0, 9) == 0, t_tr,
              $urandom_range(0, 3) != 0);
      end
    end

    chk_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || stat_q.size() != 0) begin
      n_errors++;
      $display("FAIL queues_drained: got %0d/%0d left, required 0/0", exp_q.size(), stat_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the NPC core front end; next generation of the plain PC register.
- Owns the fetch PC; hands it to instruction fetch over a valid/ready handshake.
- Advances sequentially on accepted fetches and applies prioritised redirects (trap > branch), with a post-reset boot delay, stall, and an epoch tag for flushing stale fetches.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h8000_0000, PC value loaded on reset; XLEN bits.
- INST_BYTES, 4, sequential increment; power of two, at least 2.
- BOOT_CYCLES, 2, cycles after reset release before the first valid PC; 0 allowed.
- EPOCH_W, 2, epoch counter width.

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  back-end hold; suppresses pc_valid.
- br_valid  input  1  branch/jump redirect request.
- br_target  input  XLEN  branch target.
- trap_valid  input  1  trap/mret redirect request.
- trap_target  input  XLEN  trap target.
- pc_valid  output  1  pc is offered to fetch.
- pc_ready  input  1  fetch accepts pc.
- pc  output  XLEN  current fetch PC.
- epoch  output  EPOCH_W  increments on every applied redirect.
- align_err  output  1  one-cycle pulse: an applied redirect target was misaligned.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_VECTOR; pc_valid=0; epoch=0; align_err=0.
  - state=BOOT; boot counter=0; pending-redirect register cleared.
- States:
  - BOOT: pc_valid=0; counter increments each cycle; go to RUN when counter==BOOT_CYCLES-1. With BOOT_CYCLES=0, enter RUN on the first edge after reset release.
  - RUN: pc_valid = ~stall.
- fire = pc_valid & pc_ready.
- Next-PC priority in RUN, evaluated each edge:
  1. trap_valid: pc <= trap_target.
  2. br_valid: pc <= br_target.
  3. fire: pc <= pc + INST_BYTES, modulo 2^XLEN; 0xFFFF_FFFC wraps to 0x0000_0000.
  4. Otherwise pc holds.
- Redirect (case 1 or 2):
  - epoch <= epoch+1, wrapping modulo 2^EPOCH_W.
  - Applied regardless of pc_ready, stall, or fire in the same cycle. The sequential increment is discarded.
  - This is the only permitted change of pc while pc_valid=1 without fire.
- Simultaneous trap_valid and br_valid: trap wins; branch dropped; epoch increments once.
- Alignment:
  - The applied target has its low log2(INST_BYTES) bits forced to 0.
  - align_err=1 in the cycle after the edge that applied a target with a non-zero low bit; 0 otherwise.
- Stall: pc_valid=0 combinationally; pc holds unless redirected. Redirects during stall are applied immediately.
- Redirect during BOOT:
  - Captured in the pending register; later requests overwrite it, trap over branch in the same cycle.
  - Applied (pc, epoch, align_err) on the BOOT→RUN edge.
  - Without a pending redirect, the first offered pc is RESET_VECTOR.
- Handshake: while pc_valid=1 and no redirect, pc is stable until fire. pc_valid depends only on state and stall, never on pc_ready.
- Reset asserted mid-operation: all state returns immediately to reset values; pending redirect lost.
- Latency: redirect request in cycle N → new pc visible in cycle N+1 (RUN).

Decomposition:
- Shared package core_pkg:
  - XLEN default, RESET_VECTOR default, INST_BYTES default.
  - State encoding enum (BOOT, RUN).
  - Redirect-cause encoding (NONE, BRANCH, TRAP), reused later by the CSR/trap unit.
- One natural sub-module: pc_redirect_arb, combinational trap>branch select plus align-mask and misalign detect. Used both for the live path and for capture into the pending register.

Test Plan:
- Reset/boot: BOOT_CYCLES=2; release rst, pc_ready=1 → pc_valid=0 for 2 cycles, then pc 0x8000_0000, 0x8000_0004, 0x8000_0008 on successive cycles; epoch=0.
- Backpressure: pc_ready=0 for 3 cycles at pc=0x8000_0008 → pc_valid=1 and pc stable; after pc_ready=1, next pc 0x8000_000C.
- Priority: in RUN, trap_valid=1 (0x8000_0100) and br_valid=1 (0x8000_0200) in the same cycle, pc_ready=1 → next pc 0x8000_0100; epoch +1 once; no sequential increment.
- Boot capture: br_valid=1, target 0x8000_0042, during BOOT → first valid pc 0x8000_0040; epoch=1; align_err pulses 1 cycle.
- Stall + wrap: pc=0xFFFF_FFFC, stall=1 → pc_valid=0 and pc held; release stall, fire → pc 0x0000_0000; epoch unchanged.
- Async reset mid-run: drop rst between edges with pc=0x8000_0020, epoch=3 → immediately pc=0x8000_0000, pc_valid=0, epoch=0.
